// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared constants for the instruction fetch stage.
//   - fetch_state_e : FSM state encoding (IDLE/REQ/HOLD plus the
//                     misaligned-target states MIS/HALT)
//   - PC_INC        : sequential PC increment in bytes
//   - MISALIGN_EXC_EN / is_misaligned() : misaligned-redirect trap,
//                     enabled when the macro FETCH_MISALIGN_EXC_EN is defined
package fetch_stage_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,  // first cycle after reset release
    S_REQ  = 3'd1,  // request outstanding, address stable until ack
    S_HOLD = 3'd2,  // instruction parked in buffer while decoder stalls
    S_MIS  = 3'd3,  // emit the misaligned-target marker next edge
    S_HALT = 3'd4   // parked after a misaligned redirect until next flush
  } fetch_state_e;

  localparam int unsigned PC_INC = 4;

`ifdef FETCH_MISALIGN_EXC_EN
  localparam bit MISALIGN_EXC_EN = 1'b1;
`else
  localparam bit MISALIGN_EXC_EN = 1'b0;
`endif

  // True when a redirect target must trap instead of being fetched.
  function automatic logic is_misaligned(input logic [1:0] i_lo);
    return MISALIGN_EXC_EN && (i_lo != 2'b00);
  endfunction

endpackage

// File: rtl/fetch_stage_buffer.sv
// fetch_buffer: single-entry instruction/PC holding register.
// Ports:
//   i_clk, i_rst_n        clock, synchronous active-low reset
//   i_clear               invalidate the entry (highest priority)
//   i_load                capture i_instr/i_pc and mark valid
//   i_unload              entry consumed, mark invalid
//   i_instr, i_pc         data to capture
//   o_valid, o_instr, o_pc  stored entry
module fetch_buffer
  import fetch_stage_pkg::*;
#(
  parameter int unsigned PC_WIDTH = 32,
  parameter int unsigned IWIDTH   = 32
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_clear,
  input  logic                i_load,
  input  logic                i_unload,
  input  logic [IWIDTH-1:0]   i_instr,
  input  logic [PC_WIDTH-1:0] i_pc,
  output logic                o_valid,
  output logic [IWIDTH-1:0]   o_instr,
  output logic [PC_WIDTH-1:0] o_pc
);

  logic                r_valid;
  logic [IWIDTH-1:0]   r_instr;
  logic [PC_WIDTH-1:0] r_pc;

  // Clear beats load so a flush never leaves a stale entry behind.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_instr <= '0;
      r_pc    <= '0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_instr <= i_instr;
      r_pc    <= i_pc;
    end else if (i_unload) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_instr = r_instr;
  assign o_pc    = r_pc;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch stage feeding the decoder.
// Owns the PC, keeps at most one memory read outstanding, presents each
// fetched word with its PC and a valid strobe, parks one word under decoder
// stall and redirects on flush.
// Optional feature: define FETCH_MISALIGN_EXC_EN to trap redirect targets
// with nonzero low bits instead of fetching them.
// Ports:
//   fs_clk, fs_rst        clock, synchronous active-low reset
//   fs_o_imem_addr/req    read address / request (held until ack)
//   fs_i_imem_ack/data    read completion and instruction word
//   fs_o_instr/pc/ce      instruction, its PC, valid strobe to decoder
//   fs_i_stall            decoder stall, outputs hold
//   fs_i_flush/new_pc     redirect request and target
//   fs_o_misaligned       fs_o_pc is a misaligned redirect target
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int unsigned          PC_WIDTH = 32,
  parameter int unsigned          IWIDTH   = 32,
  parameter logic [PC_WIDTH-1:0]  RESET_PC = '0
) (
  input  logic                fs_clk,
  input  logic                fs_rst,
  output logic [PC_WIDTH-1:0] fs_o_imem_addr,
  output logic                fs_o_imem_req,
  input  logic                fs_i_imem_ack,
  input  logic [IWIDTH-1:0]   fs_i_imem_data,
  output logic [IWIDTH-1:0]   fs_o_instr,
  output logic [PC_WIDTH-1:0] fs_o_pc,
  output logic                fs_o_ce,
  input  logic                fs_i_stall,
  input  logic                fs_i_flush,
  input  logic [PC_WIDTH-1:0] fs_i_new_pc,
  output logic                fs_o_misaligned
);

  localparam logic [PC_WIDTH-1:0] PC_STEP = PC_WIDTH'(PC_INC);

  fetch_state_e        r_state;
  logic [PC_WIDTH-1:0] r_addr;
  logic                r_req;
  logic                r_ce;
  logic [IWIDTH-1:0]   r_instr;
  logic [PC_WIDTH-1:0] r_pc;
  logic                r_mis;
  logic                r_discard;
  logic [PC_WIDTH-1:0] r_target;

  logic                w_pending;
  logic                w_flush_now;
  logic                w_flush_defer;
  logic                w_drop_ack;
  logic                w_redirect;
  logic [PC_WIDTH-1:0] w_redir_pc;
  logic                w_redir_mis;
  logic                w_buf_load;
  logic                w_buf_unload;
  logic                w_buf_valid;
  logic [IWIDTH-1:0]   w_buf_instr;
  logic [PC_WIDTH-1:0] w_buf_pc;

  // A request still waiting for its ack cannot be cancelled on the bus.
  assign w_pending     = (r_state == S_REQ) && !fs_i_imem_ack;
  assign w_flush_now   = fs_i_flush && !w_pending;
  assign w_flush_defer = fs_i_flush && w_pending;
  // Ack of a request issued before a deferred flush: drop it and redirect.
  assign w_drop_ack    = !fs_i_flush && (r_state == S_REQ) && fs_i_imem_ack && r_discard;
  assign w_redirect    = w_flush_now || w_drop_ack;
  assign w_redir_pc    = fs_i_flush ? fs_i_new_pc : r_target;
  assign w_redir_mis   = is_misaligned(w_redir_pc[1:0]);

  assign w_buf_load   = !fs_i_flush && (r_state == S_REQ) && fs_i_imem_ack
                        && !r_discard && fs_i_stall;
  assign w_buf_unload = !fs_i_flush && (r_state == S_HOLD) && !fs_i_stall;

  fetch_buffer #(
    .PC_WIDTH (PC_WIDTH),
    .IWIDTH   (IWIDTH)
  ) u_buf (
    .i_clk    (fs_clk),
    .i_rst_n  (fs_rst),
    .i_clear  (fs_i_flush),
    .i_load   (w_buf_load),
    .i_unload (w_buf_unload),
    .i_instr  (fs_i_imem_data),
    .i_pc     (r_addr),
    .o_valid  (w_buf_valid),
    .o_instr  (w_buf_instr),
    .o_pc     (w_buf_pc)
  );

  // Fetch FSM, PC, discard flag and decoder-facing output registers.
  always_ff @(posedge fs_clk) begin
    if (!fs_rst) begin
      r_state   <= S_IDLE;
      r_addr    <= RESET_PC;
      r_req     <= 1'b0;
      r_ce      <= 1'b0;
      r_instr   <= '0;
      r_pc      <= '0;
      r_mis     <= 1'b0;
      r_discard <= 1'b0;
      r_target  <= '0;
    end else if (w_redirect) begin
      r_discard <= 1'b0;
      r_addr    <= w_redir_pc;
      // A dropped ack under stall leaves the (already bubbled) outputs alone.
      if (fs_i_flush || !fs_i_stall) begin
        r_ce  <= 1'b0;
        r_mis <= 1'b0;
      end
      if (w_redir_mis) begin
        r_req   <= 1'b0;
        r_state <= S_MIS;
      end else begin
        r_req   <= 1'b1;
        r_state <= S_REQ;
      end
    end else if (w_flush_defer) begin
      // Keep addr/req stable for the in-flight read; a later flush overwrites.
      r_discard <= 1'b1;
      r_target  <= fs_i_new_pc;
      r_ce      <= 1'b0;
      r_mis     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_req   <= 1'b1;
          r_state <= S_REQ;
        end
        S_REQ: begin
          if (fs_i_imem_ack) begin
            if (fs_i_stall) begin
              r_req   <= 1'b0;
              r_state <= S_HOLD;
            end else begin
              r_instr <= fs_i_imem_data;
              r_pc    <= r_addr;
              r_ce    <= 1'b1;
              r_mis   <= 1'b0;
              r_addr  <= r_addr + PC_STEP;
            end
          end else if (!fs_i_stall) begin
            r_ce  <= 1'b0;
            r_mis <= 1'b0;
          end
        end
        S_HOLD: begin
          // Buffered word goes out and the next fetch starts the same edge.
          if (!fs_i_stall) begin
            r_instr <= w_buf_instr;
            r_pc    <= w_buf_pc;
            r_ce    <= w_buf_valid;
            r_mis   <= 1'b0;
            r_addr  <= w_buf_pc + PC_STEP;
            r_req   <= 1'b1;
            r_state <= S_REQ;
          end
        end
        S_MIS: begin
          r_instr <= '0;
          r_pc    <= r_addr;
          r_ce    <= 1'b1;
          r_mis   <= 1'b1;
          r_state <= S_HALT;
        end
        S_HALT: begin
          if (!fs_i_stall) begin
            r_ce  <= 1'b0;
            r_mis <= 1'b0;
          end
        end
        default: begin
          r_req   <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign fs_o_imem_addr  = r_addr;
  assign fs_o_imem_req   = r_req;
  assign fs_o_instr      = r_instr;
  assign fs_o_pc         = r_pc;
  assign fs_o_ce         = r_ce;
  assign fs_o_misaligned = r_mis;

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: latency-configurable memory model, a cycle
// table for zero-wait/stall/flush, hand sequences for slow memory, deferred
// flush and misaligned redirect, and an ordered scoreboard of words the
// decoder consumes (ce=1 with stall=0).
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] addr;
  logic        req;
  logic        ack;
  logic [31:0] rdata;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        ce;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] new_pc = 32'h0;
  logic        mis;

  int n_checks = 0;
  int n_err    = 0;

  fetch_stage #(
    .PC_WIDTH (32),
    .IWIDTH   (32),
    .RESET_PC (32'h100)
  ) dut (
    .fs_clk          (clk),
    .fs_rst          (rst_n),
    .fs_o_imem_addr  (addr),
    .fs_o_imem_req   (req),
    .fs_i_imem_ack   (ack),
    .fs_i_imem_data  (rdata),
    .fs_o_instr      (instr),
    .fs_o_pc         (pc),
    .fs_o_ce         (ce),
    .fs_i_stall      (stall),
    .fs_i_flush      (flush),
    .fs_i_new_pc     (new_pc),
    .fs_o_misaligned (mis)
  );

  always #5 clk = ~clk;

  // Memory: ack after 'lat' wait cycles of a held request; data = addr^0xFFFF.
  int lat = 0;
  int cnt = 0;
  assign ack   = req && (cnt >= lat);
  assign rdata = addr ^ 32'h0000_FFFF;
  always @(posedge clk) begin
    if (!req || ack) cnt <= 0;
    else             cnt <= cnt + 1;
  end

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        mis;
  } exp_t;
  exp_t sbq[$];
  exp_t sb_e;

  typedef struct {
    logic        stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_ce;
    logic [31:0] exp_pc;
  } vec_t;
  vec_t tab[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] p, input logic [31:0] ins, input logic m);
    exp_t e;
    e.pc = p; e.instr = ins; e.mis = m;
    sbq.push_back(e);
  endtask

  // Decoder side: a word is consumed in a cycle where ce=1 and stall=0.
  task automatic monitor();
    if (ce && !stall) begin
      if (sbq.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL sb_extra: got pc %h expected no output", pc);
      end else begin
        sb_e = sbq.pop_front();
        chk("sb_pc", pc, sb_e.pc);
        chk("sb_instr", instr, sb_e.instr);
        chk("sb_mis", 32'(mis), 32'(sb_e.mis));
      end
    end
  endtask

  // One clock: drive inputs, observe consumption mid-cycle, settle after edge.
  task automatic step(input logic s, input logic f, input logic [31:0] npc);
    stall  = s;
    flush  = f;
    new_pc = npc;
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; new_pc = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ce", 32'(ce), 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_req", 32'(req), 32'h0);
    chk("rst_addr", addr, 32'h100);
    chk("rst_mis", 32'(mis), 32'h0);
    rst_n = 1'b1;
  endtask

  task automatic end_section(input string name);
    chk(name, 32'(sbq.size()), 32'h0);
    sbq.delete();
  endtask

  function automatic vec_t mk(input logic s, input logic f, input logic [31:0] np,
                              input logic er, input logic [31:0] ea,
                              input logic ec, input logic [31:0] ep);
    vec_t v;
    v.stall = s; v.flush = f; v.new_pc = np;
    v.exp_req = er; v.exp_addr = ea; v.exp_ce = ec; v.exp_pc = ep;
    return v;
  endfunction

  initial begin
    int unsigned e_addr;
    logic        e_ce;

    // stall  flush new_pc      -> req addr        ce pc
    tab[0]  = mk(0, 0, 32'h0,    1, 32'h100, 0, 32'h0);
    tab[1]  = mk(0, 0, 32'h0,    1, 32'h104, 1, 32'h100);
    tab[2]  = mk(1, 0, 32'h0,    0, 32'h104, 1, 32'h100);
    tab[3]  = mk(1, 0, 32'h0,    0, 32'h104, 1, 32'h100);
    tab[4]  = mk(0, 0, 32'h0,    1, 32'h108, 1, 32'h104);
    tab[5]  = mk(0, 0, 32'h0,    1, 32'h10C, 1, 32'h108);
    tab[6]  = mk(0, 0, 32'h0,    1, 32'h110, 1, 32'h10C);
    tab[7]  = mk(1, 1, 32'h300,  1, 32'h300, 0, 32'h0);
    tab[8]  = mk(1, 0, 32'h0,    0, 32'h300, 0, 32'h0);
    tab[9]  = mk(0, 0, 32'h0,    1, 32'h304, 1, 32'h300);
    tab[10] = mk(0, 0, 32'h0,    1, 32'h308, 1, 32'h304);
    tab[11] = mk(1, 0, 32'h0,    0, 32'h308, 1, 32'h304);

    // Zero-wait stream, stall/release, flush with simultaneous ack and stall.
    lat = 0;
    push(32'h100, 32'h100 ^ 32'hFFFF, 1'b0);
    push(32'h104, 32'h104 ^ 32'hFFFF, 1'b0);
    push(32'h108, 32'h108 ^ 32'hFFFF, 1'b0);
    push(32'h300, 32'h300 ^ 32'hFFFF, 1'b0);
    do_reset();
    for (int i = 0; i < 12; i++) begin
      step(tab[i].stall, tab[i].flush, tab[i].new_pc);
      chk($sformatf("A%0d_req", i), 32'(req), 32'(tab[i].exp_req));
      chk($sformatf("A%0d_addr", i), addr, tab[i].exp_addr);
      chk($sformatf("A%0d_ce", i), 32'(ce), 32'(tab[i].exp_ce));
      if (tab[i].exp_ce) chk($sformatf("A%0d_pc", i), pc, tab[i].exp_pc);
    end
    end_section("A_drain");

    // Ack on the third cycle of each request, then a deferred double flush.
    lat = 2;
    push(32'h100, 32'h100 ^ 32'hFFFF, 1'b0);
    push(32'h104, 32'h104 ^ 32'hFFFF, 1'b0);
    push(32'h200, 32'h200 ^ 32'hFFFF, 1'b0);
    do_reset();
    step(0, 0, 32'h0);
    chk("B1_req", 32'(req), 32'h1);
    chk("B1_addr", addr, 32'h100);
    for (int n = 2; n <= 7; n++) begin
      step(0, 0, 32'h0);
      e_ce   = (n % 3 == 1);
      e_addr = 32'h100 + 4 * ((n - 1) / 3);
      chk($sformatf("B%0d_req", n), 32'(req), 32'h1);
      chk($sformatf("B%0d_addr", n), addr, e_addr);
      chk($sformatf("B%0d_ce", n), 32'(ce), 32'(e_ce));
      if (e_ce) chk($sformatf("B%0d_pc", n), pc, e_addr - 32'h4);
    end
    step(0, 1, 32'h1F0);
    chk("B8_ce", 32'(ce), 32'h0);
    chk("B8_addr_held", addr, 32'h108);
    chk("B8_req", 32'(req), 32'h1);
    step(0, 1, 32'h200);
    chk("B9_ce", 32'(ce), 32'h0);
    chk("B9_addr_held", addr, 32'h108);
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 32'h0);
      chk($sformatf("B%0d_ce", 10 + k), 32'(ce), 32'h0);
      chk($sformatf("B%0d_addr", 10 + k), addr, 32'h200);
      chk($sformatf("B%0d_req", 10 + k), 32'(req), 32'h1);
    end
    step(0, 0, 32'h0);
    chk("B13_ce", 32'(ce), 32'h1);
    chk("B13_pc", pc, 32'h200);
    chk("B13_instr", instr, 32'h0000_FDFF);
    chk("B13_addr", addr, 32'h204);
    step(0, 0, 32'h0);
    step(1, 0, 32'h0);
    end_section("B_drain");

    // Redirect to a misaligned target.
    lat = 0;
    push(32'h100, 32'h100 ^ 32'hFFFF, 1'b0);
`ifdef FETCH_MISALIGN_EXC_EN
    push(32'h202, 32'h0, 1'b1);
`else
    push(32'h202, 32'h202 ^ 32'hFFFF, 1'b0);
`endif
    do_reset();
    step(0, 0, 32'h0);
    step(0, 0, 32'h0);
    chk("D2_ce", 32'(ce), 32'h1);
    chk("D2_pc", pc, 32'h100);
    step(0, 1, 32'h202);
    chk("D3_ce", 32'(ce), 32'h0);
`ifdef FETCH_MISALIGN_EXC_EN
    chk("D3_req", 32'(req), 32'h0);
    step(0, 0, 32'h0);
    chk("D4_req", 32'(req), 32'h0);
    chk("D4_ce", 32'(ce), 32'h1);
    chk("D4_mis", 32'(mis), 32'h1);
    chk("D4_pc", pc, 32'h202);
    chk("D4_instr", instr, 32'h0);
    step(0, 0, 32'h0);
    chk("D5_ce", 32'(ce), 32'h0);
    chk("D5_req", 32'(req), 32'h0);
`else
    chk("D3_req", 32'(req), 32'h1);
    chk("D3_addr", addr, 32'h202);
    step(0, 0, 32'h0);
    chk("D4_ce", 32'(ce), 32'h1);
    chk("D4_mis", 32'(mis), 32'h0);
    chk("D4_pc", pc, 32'h202);
    chk("D4_instr", instr, 32'h0000_FDFD);
    chk("D4_addr", addr, 32'h206);
    step(0, 0, 32'h0);
`endif
    step(1, 0, 32'h0);
    end_section("D_drain");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
